cdb_arbiter: RTL and testbench

Multi-channel completion stage and common data bus arbiter. It sits between the functional units (ALUs, multiplier, branch unit, LSQ) and the CDB. Each channel has a small completion queue, and up to NUM_CDB results per cycle are broadcast with round-robin fairness. It also drives one register-file write port per CDB lane and applies backpressure to producers whose queue is full.

---
 rtl/cdb_arbiter_pkg.sv | 31 +++
 rtl/cdb_chan_fifo.sv | 81 ++++++++
 rtl/cdb_arbiter.sv | 96 +++++++++
 tb/tb_cdb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the completion stage / CDB arbiter.
//   CDB_PACKET    : broadcast record (valid, done, dest, branch info, data)
//   XLEN          : datapath width
//   ZERO_REG      : architectural zero register (never written back)
//   CDB_NUM_CH    : default producer channel count
//   CDB_NUM_LANES : default broadcast lanes per cycle
//   CDB_QDEPTH    : default entries per channel queue
package cdb_arbiter_pkg;

  localparam int unsigned XLEN          = 32;
  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam int unsigned CDB_NUM_CH    = 4;
  localparam int unsigned CDB_NUM_LANES = 2;
  localparam int unsigned CDB_QDEPTH    = 2;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [4:0]      dest_reg_idx;
    logic            take_branch;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] Value;
  } CDB_PACKET;

  // Link-register writes for taken branches carry NPC instead of the ALU result.
  function automatic logic [XLEN-1:0] lane_value(input CDB_PACKET p);
    return p.take_branch ? p.NPC : p.alu_result;
  endfunction

endpackage

// File: rtl/cdb_chan_fifo.sv
// One producer channel's completion queue.
//   clock, reset(async, active-low), squash : clocking / flush
//   in_valid, in_packet : producer offer
//   pop                 : head granted by the arbiter this cycle
//   head, head_valid    : current head presented for arbitration
//   ready               : queue can accept this cycle (low during reset)
// Build option: CDB_BYPASS_EN lets an empty queue present the incoming
// accepted packet as its head in the same cycle.
module cdb_chan_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned QDEPTH = CDB_QDEPTH
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      squash,
  input  logic      in_valid,
  input  CDB_PACKET in_packet,
  input  logic      pop,
  output CDB_PACKET head,
  output logic      head_valid,
  output logic      ready
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(QDEPTH - 1);

  CDB_PACKET     mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          empty, accept, bypass, do_enq, do_deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign ready  = reset && (count < DEPTH_C);
  assign accept = in_valid && ready && !squash;

`ifdef CDB_BYPASS_EN
  assign bypass     = empty && accept;
  assign head       = empty ? in_packet : mem[rd_ptr];
  assign head_valid = !empty || accept;
`else
  assign bypass     = 1'b0;
  assign head       = mem[rd_ptr];
  assign head_valid = !empty;
`endif

  // A bypassed packet that is granted leaves directly and never occupies a slot.
  assign do_deq = pop && !empty;
  assign do_enq = accept && !(bypass && pop);

  always_ff @(posedge clock) begin
    if (do_enq) mem[wr_ptr] <= in_packet;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-channel completion stage and common data bus arbiter.
//   clock, reset(async, active-low), squash(sync flush)
//   ch_valid/ch_packet/ch_ready : per-channel producer handshake
//   cdb_packet                  : registered broadcast lanes (.valid = live)
//   wb_regfile_en/idx/data      : register-file write port per lane
// Up to NUM_CDB non-empty channel heads are granted per cycle, scanning
// round-robin from rr_ptr. Build option: CDB_BYPASS_EN (see cdb_chan_fifo).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH  = CDB_NUM_CH,
  parameter int unsigned NUM_CDB = CDB_NUM_LANES,
  parameter int unsigned QDEPTH  = CDB_QDEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic      [NUM_CH-1:0]         ch_valid,
  input  CDB_PACKET [NUM_CH-1:0]         ch_packet,
  output logic      [NUM_CH-1:0]         ch_ready,
  output CDB_PACKET [NUM_CDB-1:0]        cdb_packet,
  output logic      [NUM_CDB-1:0]        wb_regfile_en,
  output logic      [NUM_CDB-1:0][4:0]   wb_regfile_idx,
  output logic      [NUM_CDB-1:0][XLEN-1:0] wb_regfile_data
);

  localparam int unsigned RW = $clog2(NUM_CH);

  CDB_PACKET [NUM_CH-1:0]  head;
  logic      [NUM_CH-1:0]  head_valid;
  logic      [NUM_CH-1:0]  pop;
  CDB_PACKET [NUM_CDB-1:0] lane_next;
  logic      [RW-1:0]      rr_ptr, rr_next, ch_sel;
  int unsigned             n_grant;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    cdb_chan_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .squash     (squash),
      .in_valid   (ch_valid[g]),
      .in_packet  (ch_packet[g]),
      .pop        (pop[g]),
      .head       (head[g]),
      .head_valid (head_valid[g]),
      .ready      (ch_ready[g])
    );
  end

  // Scan order is rr_ptr, rr_ptr+1, ... (mod NUM_CH); the n-th eligible head
  // fills lane n. rr_ptr moves past the last granted channel.
  always_comb begin
    pop       = '0;
    lane_next = '0;
    rr_next   = rr_ptr;
    n_grant   = 0;
    ch_sel    = '0;
    if (!squash) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        ch_sel = RW'((32'(rr_ptr) + k) % NUM_CH);
        if (head_valid[ch_sel] && (n_grant < NUM_CDB)) begin
          pop[ch_sel] = 1'b1;
          for (int unsigned l = 0; l < NUM_CDB; l++) begin
            if (l == n_grant) begin
              lane_next[l]       = head[ch_sel];
              lane_next[l].valid = 1'b1;
              lane_next[l].done  = 1'b1;
              lane_next[l].Value = lane_value(head[ch_sel]);
            end
          end
          rr_next = RW'((32'(ch_sel) + 32'd1) % NUM_CH);
          n_grant = n_grant + 1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      cdb_packet <= '0;
    end else begin
      rr_ptr     <= rr_next;
      cdb_packet <= lane_next;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < NUM_CDB; l++) begin
      wb_regfile_en[l]   = cdb_packet[l].valid && (cdb_packet[l].dest_reg_idx != ZERO_REG);
      wb_regfile_idx[l]  = cdb_packet[l].dest_reg_idx;
      wb_regfile_data[l] = cdb_packet[l].Value;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned NL  = 2;
  localparam int unsigned QD  = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     squash;
  logic      [NCH-1:0]      ch_valid;
  CDB_PACKET [NCH-1:0]      ch_packet;
  logic      [NCH-1:0]      ch_ready;
  CDB_PACKET [NL-1:0]       cdb_packet;
  logic      [NL-1:0]       wb_regfile_en;
  logic      [NL-1:0][4:0]  wb_regfile_idx;
  logic      [NL-1:0][XLEN-1:0] wb_regfile_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_CH(NCH), .NUM_CDB(NL), .QDEPTH(QD)) dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .ch_valid        (ch_valid),
    .ch_packet       (ch_packet),
    .ch_ready        (ch_ready),
    .cdb_packet      (cdb_packet),
    .wb_regfile_en   (wb_regfile_en),
    .wb_regfile_idx  (wb_regfile_idx),
    .wb_regfile_data (wb_regfile_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: per-channel expected queue contents (FIFO order per channel).
  CDB_PACKET   mq [NCH][$];
  CDB_PACKET   pend [NCH];
  int unsigned m_rr = 0;
  int unsigned seq = 0;
  int unsigned n_acc = 0, n_bcast = 0, n_drop = 0;
  int unsigned lane_ch [NL];

  function automatic CDB_PACKET gen(input int unsigned ch);
    CDB_PACKET p;
    seq++;
    p.valid        = seq[0];
    p.done         = seq[1];
    p.dest_reg_idx = 5'($urandom_range(0, 31));
    p.take_branch  = 1'($urandom_range(0, 1));
    p.NPC          = 32'h4000_0000 | (seq << 2);
    p.alu_result   = {8'(ch), 24'(seq)};
    p.Value        = 32'hDEAD_BEEF;
    return p;
  endfunction

  function automatic CDB_PACKET mk(input logic [4:0] dest, input logic tb,
                                   input logic [31:0] npc, input logic [31:0] alu);
    CDB_PACKET p;
    p.valid = 1'b0; p.done = 1'b0; p.dest_reg_idx = dest; p.take_branch = tb;
    p.NPC = npc; p.alu_result = alu; p.Value = 32'hFFFF_FFFF;
    return p;
  endfunction

  function automatic CDB_PACKET to_lane(input CDB_PACKET p);
    CDB_PACKET r;
    r = p;
    r.valid = 1'b1;
    r.done  = 1'b1;
    r.Value = p.take_branch ? p.NPC : p.alu_result;
    return r;
  endfunction

  // One cycle: called at a negedge, drives inputs, predicts, checks after the posedge.
  task automatic step(input logic [NCH-1:0] v, input logic sq);
    logic [NCH-1:0] acc, grant;
    CDB_PACKET      el [NL];
    logic [NL-1:0]  ev;
    int unsigned    n, last;
    ch_valid = v;
    squash   = sq;
    for (int i = 0; i < NCH; i++) ch_packet[i] = pend[i];
    #1;
    acc = '0; grant = '0; ev = '0; n = 0; last = 0;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("ready%0d", i), 128'(ch_ready[i]), 128'(mq[i].size() < QD));
      acc[i] = v[i] && (mq[i].size() < QD) && !sq;
    end
    if (!sq) begin
      for (int k = 0; k < NCH; k++) begin
        int unsigned c;
        c = (m_rr + k) % NCH;
        if (mq[c].size() > 0 && n < NL) begin
          el[n] = to_lane(mq[c][0]);
          ev[n] = 1'b1;
          grant[c] = 1'b1;
          last = c;
          n++;
        end
      end
    end
    @(posedge clock);
    #1;
    for (int l = 0; l < NL; l++) begin
      lane_ch[l] = 32'(cdb_packet[l].alu_result[31:24]);
      if (cdb_packet[l].valid) n_bcast++;
      if (ev[l]) begin
        check($sformatf("lane%0d_pkt", l), 128'(cdb_packet[l]), 128'(el[l]));
        check($sformatf("lane%0d_en", l), 128'(wb_regfile_en[l]), 128'(el[l].dest_reg_idx != ZERO_REG));
        check($sformatf("lane%0d_idx", l), 128'(wb_regfile_idx[l]), 128'(el[l].dest_reg_idx));
        check($sformatf("lane%0d_data", l), 128'(wb_regfile_data[l]), 128'(el[l].Value));
      end else begin
        check($sformatf("lane%0d_idle_pkt", l), 128'(cdb_packet[l]), 128'(0));
        check($sformatf("lane%0d_idle_en", l), 128'(wb_regfile_en[l]), 128'(0));
        check($sformatf("lane%0d_idle_idx", l), 128'(wb_regfile_idx[l]), 128'(0));
        check($sformatf("lane%0d_idle_data", l), 128'(wb_regfile_data[l]), 128'(0));
      end
    end
    if (sq) begin
      for (int i = 0; i < NCH; i++) begin
        n_drop += mq[i].size();
        mq[i].delete();
        pend[i] = gen(i);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (grant[i]) void'(mq[i].pop_front());
        if (acc[i]) begin
          mq[i].push_back(pend[i]);
          n_acc++;
          pend[i] = gen(i);
        end
      end
      if (n > 0) m_rr = (last + 1) % NCH;
    end
    @(negedge clock);
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    for (int i = 0; i < 12 && !model_empty(); i++) step('0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; squash = 1'b0; ch_valid = '0; ch_packet = '0;
    for (int i = 0; i < NCH; i++) pend[i] = gen(i);
    @(negedge clock);
    @(negedge clock);
    check("rst_ready", 128'(ch_ready), 128'(0));
    for (int l = 0; l < NL; l++) begin
      check("rst_pkt", 128'(cdb_packet[l]), 128'(0));
      check("rst_en", 128'(wb_regfile_en[l]), 128'(0));
    end
    reset = 1'b1;

    // Fairness / backpressure: every channel offers every cycle.
    for (int j = 0; j < 8; j++) begin
      step('1, 1'b0);
      if (j >= 1) begin
        check("fair_l0", 128'(lane_ch[0]), 128'(((j - 1) % 2) * 2));
        check("fair_l1", 128'(lane_ch[1]), 128'(((j - 1) % 2) * 2 + 1));
        check("fair_rr", 128'(dut.rr_ptr), 128'((j % 2 == 1) ? 2 : 0));
      end
      if (j == 1) check("bp_ready3", 128'(ch_ready[3]), 128'(0));
    end
    drain();

    // Single result, two-edge latency.
    pend[0] = mk(5'd5, 1'b0, 32'h0000_0200, 32'h0000_1234);
    step(4'b0001, 1'b0);
    check("single_early", 128'(cdb_packet[0].valid), 128'(0));
    step('0, 1'b0);
    check("single_valid", 128'(cdb_packet[0].valid), 128'(1));
    check("single_value", 128'(cdb_packet[0].Value), 128'(32'h1234));
    check("single_en", 128'(wb_regfile_en[0]), 128'(1));
    check("single_idx", 128'(wb_regfile_idx[0]), 128'(5));
    check("single_l1", 128'(cdb_packet[1].valid), 128'(0));

    // Branch link value, then the same to the zero register.
    pend[1] = mk(5'd7, 1'b1, 32'h0000_0104, 32'h0000_0200);
    step(4'b0010, 1'b0);
    step('0, 1'b0);
    check("br_data", 128'(wb_regfile_data[0]), 128'(32'h104));
    check("br_value", 128'(cdb_packet[0].Value), 128'(32'h104));
    pend[1] = mk(5'd0, 1'b1, 32'h0000_0104, 32'h0000_0200);
    step(4'b0010, 1'b0);
    step('0, 1'b0);
    check("zero_en", 128'(wb_regfile_en[0]), 128'(0));
    check("zero_valid", 128'(cdb_packet[0].valid), 128'(1));

    // Squash with three entries queued and a new packet in the squash cycle.
    step(4'b0111, 1'b0);
    pend[0] = mk(5'd9, 1'b0, 32'h0, 32'hBAD0_0000);
    step(4'b0001, 1'b1);
    check("sq_l0", 128'(cdb_packet[0].valid), 128'(0));
    check("sq_l1", 128'(cdb_packet[1].valid), 128'(0));
    check("sq_ready", 128'(ch_ready), 128'(4'hF));
    for (int i = 0; i < 3; i++) step('0, 1'b0);

    // Random traffic with occasional squash.
    for (int i = 0; i < 80; i++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 19) == 0));
    drain();

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step('1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ready", 128'(ch_ready), 128'(0));
    for (int l = 0; l < NL; l++) begin
      check("arst_pkt", 128'(cdb_packet[l]), 128'(0));
      check("arst_en", 128'(wb_regfile_en[l]), 128'(0));
      check("arst_data", 128'(wb_regfile_data[l]), 128'(0));
    end
    for (int i = 0; i < NCH; i++) begin
      n_drop += mq[i].size();
      mq[i].delete();
    end
    m_rr = 0;
    @(posedge clock);
    #1;
    check("arst_hold", 128'(cdb_packet[0]), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step('0, 1'b0);
    pend[2] = mk(5'd3, 1'b0, 32'h0, 32'hCAFE_0002);
    step(4'b0100, 1'b0);
    check("post_rst_early", 128'(cdb_packet[0].valid), 128'(0));
    step('0, 1'b0);
    check("post_rst_alu", 128'(cdb_packet[0].alu_result), 128'(32'hCAFE_0002));
    drain();

    check("conserve", 128'(n_bcast + n_drop), 128'(n_acc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
